// File: rtl/pe_req_ctrl_if.sv
// Bundle between pe_req_ctrl, its request sources, the priority encoder and the grant consumer.
// Defining PE_REQ_CTRL_OVERFLOW_EN adds the ovf status vector and its ovf_clr strobe.
interface pe_req_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int ID_W  = 4
);
  logic [WIDTH-1:0] req_in;
  logic             mask_we;
  logic [WIDTH-1:0] mask_wdata;
  logic [WIDTH-1:0] enc_in;
  logic [WIDTH-1:0] enc_out;
  logic             enc_valid;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_onehot;
  logic [ID_W-1:0]  grant_id;
  logic             grant_ack;
  logic [WIDTH-1:0] pending;
`ifdef PE_REQ_CTRL_OVERFLOW_EN
  logic [WIDTH-1:0] ovf;
  logic             ovf_clr;

  modport master (
    output req_in, mask_we, mask_wdata, enc_out, enc_valid, grant_ack, ovf_clr,
    input  enc_in, grant_valid, grant_onehot, grant_id, pending, ovf
  );
  modport slave (
    input  req_in, mask_we, mask_wdata, enc_out, enc_valid, grant_ack, ovf_clr,
    output enc_in, grant_valid, grant_onehot, grant_id, pending, ovf
  );
`else
  modport master (
    output req_in, mask_we, mask_wdata, enc_out, enc_valid, grant_ack,
    input  enc_in, grant_valid, grant_onehot, grant_id, pending
  );
  modport slave (
    input  req_in, mask_we, mask_wdata, enc_out, enc_valid, grant_ack,
    output enc_in, grant_valid, grant_onehot, grant_id, pending
  );
`endif
endinterface

// File: rtl/pe_req_ctrl.sv
// Request capture, masking and grant sequencing around an external 16-bit priority encoder.
// Optional overflow tracking of duplicate captures is enabled by PE_REQ_CTRL_OVERFLOW_EN.
module pe_req_ctrl #(
  parameter int WIDTH     = 16,
  parameter int ID_W      = 4,
  parameter bit EDGE_MODE = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  pe_req_ctrl_if.slave bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] req_prev_q;
  logic             grant_valid_q;
  logic [WIDTH-1:0] grant_onehot_q;
  logic [ID_W-1:0]  grant_id_q;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] retire;

  function automatic logic [ID_W-1:0] encode(input logic [WIDTH-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  // A new capture is OR-ed in after the retire mask, so a same-cycle set beats the ack clear.
  always_comb begin
    capture   = EDGE_MODE ? (bus.req_in & ~req_prev_q) : bus.req_in;
    retire    = (state_q == ISSUE && bus.grant_ack) ? grant_onehot_q : '0;
    pending_d = (pending_q & ~retire) | capture;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      mask_q     <= '1;
      req_prev_q <= '0;
    end else begin
      pending_q  <= pending_d;
      req_prev_q <= bus.req_in;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
    end
  end

`ifdef PE_REQ_CTRL_OVERFLOW_EN
  logic [WIDTH-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = (bus.ovf_clr ? '0 : ovf_q) | (capture & pending_q & ~retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

  // Grant stays frozen through ISSUE; mask changes only affect the next arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_valid_q  <= 1'b0;
      grant_onehot_q <= '0;
      grant_id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enc_valid) begin
            grant_onehot_q <= bus.enc_out;
            grant_id_q     <= encode(bus.enc_out);
            grant_valid_q  <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.grant_ack) begin
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          grant_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign bus.enc_in       = pending_q & mask_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_pe_req_ctrl.sv
// Directed bench for pe_req_ctrl with a lowest-index-wins encoder model.
// Build with PE_REQ_CTRL_OVERFLOW_EN defined to also exercise the ovf vector.
module tb_pe_req_ctrl;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pe_req_ctrl_if #(.WIDTH(16), .ID_W(4)) bus ();

  pe_req_ctrl #(.WIDTH(16), .ID_W(4), .EDGE_MODE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural priority encoder: isolate the lowest set bit.
  assign bus.enc_out   = bus.enc_in & (~bus.enc_in + 16'd1);
  assign bus.enc_valid = |bus.enc_in;

  task automatic applyStimulus(input logic [15:0] req, input logic ack,
                               input logic mwe, input logic [15:0] mdata);
    bus.req_in     = req;
    bus.grant_ack  = ack;
    bus.mask_we    = mwe;
    bus.mask_wdata = mdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req_in     = '0;
    bus.grant_ack  = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
`ifdef PE_REQ_CTRL_OVERFLOW_EN
    bus.ovf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pending", bus.pending, 16'h0000);
    checkOutput("rst_gvalid", {15'd0, bus.grant_valid}, 16'h0000);
    checkOutput("rst_enc_in", bus.enc_in, 16'h0000);
    checkOutput("rst_gonehot", bus.grant_onehot, 16'h0000);
    checkOutput("rst_gid", {12'd0, bus.grant_id}, 16'h0000);
`ifdef PE_REQ_CTRL_OVERFLOW_EN
    checkOutput("rst_ovf", bus.ovf, 16'h0000);
`endif
    rst_n = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);

    $display("[TB] single request on bit 5");
    applyStimulus(16'h0020, 1'b0, 1'b0, 16'h0000);
    checkOutput("b5_pending", bus.pending, 16'h0020);
    checkOutput("b5_enc_in_fullmask", bus.enc_in, 16'h0020);
    checkOutput("b5_gvalid_early", {15'd0, bus.grant_valid}, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b5_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    checkOutput("b5_gonehot", bus.grant_onehot, 16'h0020);
    checkOutput("b5_gid", {12'd0, bus.grant_id}, 16'h0005);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b5_hold", {15'd0, bus.grant_valid}, 16'h0001);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    checkOutput("b5_ack_pending", bus.pending, 16'h0000);
    checkOutput("b5_ack_gvalid", {15'd0, bus.grant_valid}, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b5_no_regrant", {15'd0, bus.grant_valid}, 16'h0000);

    $display("[TB] bits 3 and 9 together");
    applyStimulus(16'h0208, 1'b0, 1'b0, 16'h0000);
    checkOutput("b39_pending", bus.pending, 16'h0208);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b39_first_gid", {12'd0, bus.grant_id}, 16'h0003);
    checkOutput("b39_first_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    checkOutput("b39_gap_gvalid", {15'd0, bus.grant_valid}, 16'h0000);
    checkOutput("b39_gap_pending", bus.pending, 16'h0200);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b39_second_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    checkOutput("b39_second_gid", {12'd0, bus.grant_id}, 16'h0009);
    checkOutput("b39_second_gonehot", bus.grant_onehot, 16'h0200);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b39_no_third", {15'd0, bus.grant_valid}, 16'h0000);
    checkOutput("b39_empty", bus.pending, 16'h0000);

    $display("[TB] masked request on bit 3");
    applyStimulus(16'h0000, 1'b0, 1'b1, 16'hFFF7);
    applyStimulus(16'h0008, 1'b0, 1'b0, 16'h0000);
    checkOutput("mask_pending", bus.pending, 16'h0008);
    checkOutput("mask_enc_in", bus.enc_in, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("mask_no_grant", {15'd0, bus.grant_valid}, 16'h0000);
    checkOutput("mask_keeps_pending", bus.pending, 16'h0008);
    applyStimulus(16'h0000, 1'b0, 1'b1, 16'hFFFF);
    checkOutput("unmask_enc_in", bus.enc_in, 16'h0008);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("unmask_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    checkOutput("unmask_gid", {12'd0, bus.grant_id}, 16'h0003);
    applyStimulus(16'h0000, 1'b0, 1'b1, 16'h0000);
    checkOutput("issue_mask_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    checkOutput("issue_mask_gonehot", bus.grant_onehot, 16'h0008);
    checkOutput("issue_mask_enc_in", bus.enc_in, 16'h0000);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    checkOutput("issue_mask_retired", bus.pending, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b1, 16'hFFFF);

    $display("[TB] bit 7 re-rises in its ack cycle");
    applyStimulus(16'h0080, 1'b0, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b7_gid", {12'd0, bus.grant_id}, 16'h0007);
    applyStimulus(16'h0080, 1'b1, 1'b0, 16'h0000);
    checkOutput("b7_set_wins", bus.pending, 16'h0080);
    checkOutput("b7_ack_gvalid", {15'd0, bus.grant_valid}, 16'h0000);
`ifdef PE_REQ_CTRL_OVERFLOW_EN
    checkOutput("b7_no_ovf", bus.ovf, 16'h0000);
`endif
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b7_regrant_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    checkOutput("b7_regrant_gid", {12'd0, bus.grant_id}, 16'h0007);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    checkOutput("b7_done", bus.pending, 16'h0000);

    $display("[TB] ack while idle is ignored");
    applyStimulus(16'h0010, 1'b1, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    checkOutput("idle_ack_pending", bus.pending, 16'h0010);
    checkOutput("idle_ack_gid", {12'd0, bus.grant_id}, 16'h0004);
    checkOutput("idle_ack_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000);
    checkOutput("idle_ack_done", bus.pending, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);

    $display("[TB] duplicate capture on bit 2, then reset in ISSUE");
    applyStimulus(16'h0004, 1'b0, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b2_gid", {12'd0, bus.grant_id}, 16'h0002);
    applyStimulus(16'h0004, 1'b0, 1'b0, 16'h0000);
    checkOutput("b2_dup_pending", bus.pending, 16'h0004);
    checkOutput("b2_dup_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
`ifdef PE_REQ_CTRL_OVERFLOW_EN
    checkOutput("b2_ovf_set", bus.ovf, 16'h0004);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("b2_ovf_sticky", bus.ovf, 16'h0004);
    bus.ovf_clr = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    bus.ovf_clr = 1'b0;
    checkOutput("b2_ovf_clr", bus.ovf, 16'h0000);
`else
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
`endif
    checkOutput("pre_rst_gvalid", {15'd0, bus.grant_valid}, 16'h0001);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_gvalid", {15'd0, bus.grant_valid}, 16'h0000);
    checkOutput("async_rst_pending", bus.pending, 16'h0000);
    checkOutput("async_rst_gonehot", bus.grant_onehot, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("post_rst_gvalid", {15'd0, bus.grant_valid}, 16'h0000);
    checkOutput("post_rst_pending", bus.pending, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
